// File: rtl/logic_pipe.sv
// logic_pipe: two-stage valid/ready pipeline computing a bitwise function of
// two operands. In chained mode the previous result (ACC) replaces operand A.
// Flags {neg, ones, zero} are derived combinationally from the S2 result.
module logic_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          CHAIN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       flags
);

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOR   = 3'd2,
    OP_XOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] result;

  // Handshake: S1 may advance when S2 is empty or draining this cycle
  always_comb begin
    s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s1_adv;
    accept   = in_valid && in_ready;
  end

  // Bitwise function of S1 contents, with ACC replacing A in chained mode
  always_comb begin
    logic [WIDTH-1:0] opa;
    op_e              fn;
    opa = (CHAIN_EN && s1_op_q[3]) ? acc_q : s1_a_q;
    fn  = op_e'(s1_op_q[2:0]);
    result = '0;
    case (fn)
      OP_AND:   result = opa & s1_b_q;
      OP_OR:    result = opa | s1_b_q;
      OP_NOR:   result = ~(opa | s1_b_q);
      OP_XOR:   result = opa ^ s1_b_q;
      OP_NAND:  result = ~(opa & s1_b_q);
      OP_XNOR:  result = ~(opa ^ s1_b_q);
      OP_ANDN:  result = opa & ~s1_b_q;
      OP_PASSA: result = opa;
      default:  result = opa;
    endcase
  end

  // Next-state: capture input into S1, move S1 into S2 (and ACC), drain S2
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    acc_d      = acc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = op;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      out_d      = result;
      acc_d      = result;
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      acc_q      <= acc_d;
    end
  end

  // Outputs and flags follow the S2 register directly
  always_comb begin
    out_valid = s2_valid_q;
    out       = out_q;
    flags     = {out_q[WIDTH-1], &out_q, ~|out_q};
  end

endmodule
